// File: rtl/key_debounce_pkg.sv
// Shared constants and types for the key debouncer.
// Counter sizing lives here so the top and any wrappers agree on it.
package key_debounce_pkg;

  localparam int unsigned CNT_NMB_DEF = 10000;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Width needed to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Only q is safe to sample in the clk domain.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronise the pin, then accept a new level only
// after it has been seen for CNT_NMB consecutive cycles; emit edge pulses.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned CNT_NMB = CNT_NMB_DEF,
  parameter logic        RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic key_o,
  output logic key_rise_o,
  output logic key_fall_o
);

  localparam int unsigned      CNT_W    = cnt_width(CNT_NMB);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CNT_NMB - 1);

  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             key_q;
  logic             key_d;
  edge_t            pulse;

  sync_2ff #(
    .RST_VAL(RST_LVL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_i),
    .q     (s2)
  );

  // Any sample matching the current level restarts qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      key_q <= RST_LVL;
    end else if (s2 == key_q) begin
      cnt <= '0;
    end else if (cnt == CNT_TERM) begin
      key_q <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Pulses appear the cycle after key_q changes, from a one-cycle delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_d      <= RST_LVL;
      pulse.rise <= 1'b0;
      pulse.fall <= 1'b0;
    end else begin
      key_d      <= key_q;
      pulse.rise <= key_q & ~key_d;
      pulse.fall <= ~key_q & key_d;
    end
  end

  assign key_o      = key_q;
  assign key_rise_o = pulse.rise;
  assign key_fall_o = pulse.fall;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed pin waveforms, expected edge pulses
// queued as {kind, cycle} and matched by a monitor on the falling clock edge.
module tb_key_debounce;

  logic clk;
  logic rst_n;
  logic key;
  logic key_o, rise, fall;
  logic key1, key1_o, rise1, fall1;
  logic keyl, keyl_o, risel, falll;

  int cyc;
  int checks;
  int failures;

  // {1 = rise / 0 = fall, negedge cycle at which the pulse must be seen}
  logic [32:0] exp_q[$];

  key_debounce #(.CNT_NMB(16)) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key),
    .key_o(key_o), .key_rise_o(rise), .key_fall_o(fall)
  );

  key_debounce #(.CNT_NMB(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .key_i(key1),
    .key_o(key1_o), .key_rise_o(rise1), .key_fall_o(fall1)
  );

  key_debounce dut_long (
    .clk(clk), .rst_n(rst_n), .key_i(keyl),
    .key_o(keyl_o), .key_rise_o(risel), .key_fall_o(falll)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic is_rise, input int at);
    exp_q.push_back({is_rise, 32'(at)});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && (rise || fall)) begin
      logic [32:0] e;
      check("pulse_exclusive", {31'd0, rise & fall}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rise, fall}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, rise}, {31'd0, e[32]});
        check("pulse_cycle", 32'(cyc), e[31:0]);
        check("level_at_pulse", {31'd0, key_o}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    int c;
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0; key = 1'b0; key1 = 1'b0; keyl = 1'b0;
    repeat (3) @(negedge clk);

    // reset with key held high: outputs stay at reset level
    key = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_key_o", {31'd0, key_o}, 32'd0);
    check("reset_pulses", {30'd0, rise, fall}, 32'd0);

    // release: key already high, key_o rises 18 cycles later
    c = cyc; rst_n = 1'b1;
    expect_pulse(1'b1, c + 19);
    wait_until(c + 17);
    check("release_before", {31'd0, key_o}, 32'd0);
    wait_until(c + 18);
    check("release_after", {31'd0, key_o}, 32'd1);
    repeat (5) @(negedge clk);

    // clean fall then clean rise
    c = cyc; key = 1'b0; expect_pulse(1'b0, c + 19);
    wait_until(c + 25);
    c = cyc; key = 1'b1; expect_pulse(1'b1, c + 19);
    wait_until(c + 17);
    check("step_before", {31'd0, key_o}, 32'd1 - 32'd1);
    wait_until(c + 18);
    check("step_after", {31'd0, key_o}, 32'd1);
    wait_until(c + 25);

    // bounce: drop to 0, then toggle every 3 cycles, then settle high
    c = cyc; key = 1'b0; expect_pulse(1'b0, c + 19);
    wait_until(c + 25);
    for (int i = 0; i < 20; i++) begin
      key = (i % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_hold", {31'd0, key_o}, 32'd0);
    c = cyc; key = 1'b1; expect_pulse(1'b1, c + 19);
    wait_until(c + 17);
    check("bounce_before", {31'd0, key_o}, 32'd0);
    wait_until(c + 18);
    check("bounce_after", {31'd0, key_o}, 32'd1);
    wait_until(c + 25);

    // 15-cycle glitch low is rejected
    c = cyc; key = 1'b0;
    wait_until(c + 15); key = 1'b1;
    wait_until(c + 40);
    check("glitch15_hold", {31'd0, key_o}, 32'd1);

    // 17-cycle low is accepted, then the return high is accepted too
    c = cyc; key = 1'b0;
    expect_pulse(1'b0, c + 19);
    expect_pulse(1'b1, c + 36);
    wait_until(c + 17); key = 1'b1;
    wait_until(c + 18);
    check("glitch17_fell", {31'd0, key_o}, 32'd0);
    wait_until(c + 45);
    check("glitch17_back", {31'd0, key_o}, 32'd1);

    // reset after 10 counts of a falling qualification
    c = cyc; key = 1'b0;
    wait_until(c + 12);
    rst_n = 1'b0;
    #1;
    check("midreset_key_o", {31'd0, key_o}, 32'd0);
    check("midreset_pulses", {30'd0, rise, fall}, 32'd0);
    key = 1'b1;
    repeat (3) @(negedge clk);
    c = cyc; rst_n = 1'b1;
    expect_pulse(1'b1, c + 19);
    wait_until(c + 17);
    check("restart_before", {31'd0, key_o}, 32'd0);
    wait_until(c + 18);
    check("restart_after", {31'd0, key_o}, 32'd1);
    wait_until(c + 25);

    // CNT_NMB=1: only the synchroniser delay remains
    c = cyc; key1 = 1'b1;
    wait_until(c + 2);
    check("one_before", {31'd0, key1_o}, 32'd0);
    wait_until(c + 3);
    check("one_after", {31'd0, key1_o}, 32'd1);
    wait_until(c + 4);
    check("one_rise", {30'd0, rise1, fall1}, 32'd2);
    wait_until(c + 5);
    check("one_rise_width", {30'd0, rise1, fall1}, 32'd0);
    c = cyc; key1 = 1'b0;
    wait_until(c + 4);
    check("one_fall", {30'd0, rise1, fall1}, 32'd1);

    // default CNT_NMB=10000
    c = cyc; keyl = 1'b1;
    wait_until(c + 10001);
    check("long_before", {31'd0, keyl_o}, 32'd0);
    wait_until(c + 10002);
    check("long_after", {31'd0, keyl_o}, 32'd1);
    wait_until(c + 10003);
    check("long_rise", {30'd0, risel, falll}, 32'd2);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
